// File: rtl/mem_ctrl.sv
// mem_ctrl: round-robin IF/LSB arbiter that sequences 1/2/4-byte requests as byte beats on the RAM/IO bus.
// Define MEM_CTRL_IO_STALL_EN to hold IO-space store beats while io_buffer_full is set.
module mem_ctrl #(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = 32'h00030000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              lsb_req,
    input  logic              lsb_ls,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [31:0]       lsb_wdata,
    input  logic [2:0]        lsb_precise,
    output logic              lsb_done,
    output logic [31:0]       lsb_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_STORE, S_DONE} state_t;
    localparam logic GRANT_IF  = 1'b0;
    localparam logic GRANT_LSB = 1'b1;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d;
    logic [2:0]        precise_q, precise_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] mem_a_d;
    logic [7:0]        mem_dout_d;
    logic              mem_wr_d, if_done_d, lsb_done_d;
    logic [31:0]       if_inst_d, lsb_rdata_d;

    logic [2:0]        n_beats;
    logic [1:0]        cap_idx;
    logic [ADDR_W-1:0] beat_addr;
    logic              if_ok, grant_lsb, acc_stall, beat_stall;

    function automatic logic [2:0] beats_of(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] pr);
        case (pr)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'b0, w[7:0]};
            3'b101:  return {16'b0, w[15:0]};
            default: return w;
        endcase
    endfunction

    assign n_beats   = (state_q == S_FETCH) ? 3'd4 : beats_of(precise_q[1:0]);
    // In read states cnt_q lags the issued beat by one, so it indexes the byte arriving now.
    assign cap_idx   = 2'(cnt_q - 3'd1);
    assign beat_addr = addr_q + ADDR_W'(cnt_q);
    assign if_ok     = if_req && !rollback;
    assign grant_lsb = lsb_req && (!if_ok || last_grant_q == GRANT_IF);

`ifdef MEM_CTRL_IO_STALL_EN
    assign acc_stall  = io_buffer_full && (lsb_addr >= IO_BASE);
    assign beat_stall = io_buffer_full && (beat_addr >= IO_BASE);
`else
    logic unused_io_full;
    assign unused_io_full = io_buffer_full;
    assign acc_stall      = 1'b0;
    assign beat_stall     = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        buf_d        = buf_q;
        precise_d    = precise_q;
        last_grant_d = last_grant_q;
        mem_a_d      = '0;
        mem_dout_d   = '0;
        mem_wr_d     = 1'b0;
        if_done_d    = 1'b0;
        lsb_done_d   = 1'b0;
        if_inst_d    = if_inst;
        lsb_rdata_d  = lsb_rdata;
        case (state_q)
            S_IDLE: begin
                if (grant_lsb) begin
                    last_grant_d = GRANT_LSB;
                    addr_d       = lsb_addr;
                    wdata_d      = lsb_wdata;
                    precise_d    = lsb_precise;
                    buf_d        = '0;
                    cnt_d        = 3'd0;
                    if (lsb_ls) begin
                        state_d = S_LOAD;
                        mem_a_d = lsb_addr;
                    end else begin
                        state_d = S_STORE;
                        if (!acc_stall) begin
                            mem_wr_d   = 1'b1;
                            mem_a_d    = lsb_addr;
                            mem_dout_d = lsb_wdata[7:0];
                            cnt_d      = 3'd1;
                        end
                    end
                end else if (if_ok) begin
                    last_grant_d = GRANT_IF;
                    addr_d       = if_addr;
                    buf_d        = '0;
                    cnt_d        = 3'd0;
                    state_d      = S_FETCH;
                    mem_a_d      = if_addr;
                end
            end
            S_FETCH, S_LOAD: begin
                if (state_q == S_FETCH && rollback) begin
                    state_d = S_IDLE;
                end else begin
                    if (cnt_q + 3'd1 < n_beats)
                        mem_a_d = addr_q + ADDR_W'(cnt_q + 3'd1);
                    if (cnt_q != 3'd0)
                        buf_d[{cap_idx, 3'b000} +: 8] = mem_din;
                    if (cnt_q == n_beats) begin
                        state_d = S_DONE;
                        if (state_q == S_FETCH) begin
                            if_done_d = 1'b1;
                            if_inst_d = buf_d;
                        end else begin
                            lsb_done_d  = 1'b1;
                            lsb_rdata_d = extend(buf_d, precise_q);
                        end
                    end
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_STORE: begin
                // cnt_q counts beats already put on the bus; the last one commits this cycle.
                if (cnt_q == n_beats) begin
                    state_d    = S_DONE;
                    lsb_done_d = 1'b1;
                end else if (!beat_stall) begin
                    mem_wr_d   = 1'b1;
                    mem_a_d    = beat_addr;
                    mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    cnt_d      = cnt_q + 3'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            buf_q        <= '0;
            precise_q    <= '0;
            last_grant_q <= GRANT_IF;
            mem_a        <= '0;
            mem_dout     <= '0;
            mem_wr       <= 1'b0;
            if_done      <= 1'b0;
            lsb_done     <= 1'b0;
            if_inst      <= '0;
            lsb_rdata    <= '0;
        end else if (rdy) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            buf_q        <= buf_d;
            precise_q    <= precise_d;
            last_grant_q <= last_grant_d;
            mem_a        <= mem_a_d;
            mem_dout     <= mem_dout_d;
            mem_wr       <= mem_wr_d;
            if_done      <= if_done_d;
            lsb_done     <= lsb_done_d;
            if_inst      <= if_inst_d;
            lsb_rdata    <= lsb_rdata_d;
        end
    end

endmodule
